// File: rtl/qsqrt_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : qsqrt_seq_if
// Purpose  : Start/complete handshake bundle for the sequential fixed-point
//            square-root unit.
// Ports    : i_start     - start request (master -> slave)
//            i_radicand  - sign-magnitude Q-format operand (master -> slave)
//            o_root      - sign-magnitude Q-format root (slave -> master)
//            o_busy      - operation in progress (slave -> master)
//            o_complete  - one-cycle result-valid pulse (slave -> master)
//            o_error     - negative-input flag, valid with o_complete
// Revision : 1.0 - initial release
// ============================================================================
interface qsqrt_seq_if #(
   parameter int N = 32
);
   logic         i_start;
   logic [N-1:0] i_radicand;
   logic [N-1:0] o_root;
   logic         o_busy;
   logic         o_complete;
   logic         o_error;

   modport master (
      output i_start, i_radicand,
      input  o_root, o_busy, o_complete, o_error
   );

   modport slave (
      input  i_start, i_radicand,
      output o_root, o_busy, o_complete, o_error
   );
endinterface
`default_nettype wire

// File: rtl/qsqrt_seq.sv
`default_nettype none
// ============================================================================
// Module   : qsqrt_seq
// Purpose  : Sequential square root of a sign-magnitude Q fixed-point value.
//            Digit-by-digit restoring algorithm, one root bit per clock.
//            Result = floor(sqrt(m * 2^Q)), m = input magnitude.
// Ports    : clk  - system clock, rising edge
//            rst  - asynchronous active-high reset
//            bus  - qsqrt_seq_if.slave (i_start, i_radicand, o_root,
//                   o_busy, o_complete, o_error)
// Revision : 1.0 - initial release
// ============================================================================
module qsqrt_seq #(
   parameter int Q = 16,
   parameter int N = 32
) (
   input  wire logic   clk,
   input  wire logic   rst,
   qsqrt_seq_if.slave  bus
);

   localparam int c_ITER = (N - 1 + Q + 1) / 2;   // root bits / iterations
   localparam int c_XW   = 2 * c_ITER;            // operand, padded to even
   localparam int c_RW   = c_ITER + 2;            // remainder width
   localparam int c_CW   = $clog2(c_ITER);

   localparam logic [c_CW-1:0] c_CNT_INIT = c_CW'(c_ITER - 1);

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_BUSY = 2'd1;
   localparam logic [1:0] c_DONE = 2'd2;

   logic [1:0]        r_state;
   logic [c_XW-1:0]   r_x;
   logic [c_RW-1:0]   r_rem;
   logic [c_ITER-1:0] r_root;
   logic [c_CW-1:0]   r_cnt;
   logic              r_neg;
   logic [N-1:0]      r_root_out;
   logic              r_busy;
   logic              r_complete;
   logic              r_error;

   logic [N-2:0]      w_mag;
   logic              w_neg;
   logic [c_XW-1:0]   w_x_init;
   logic [c_RW-1:0]   w_rem_sh;
   logic [c_RW-1:0]   w_trial;
   logic              w_fits;

   assign w_mag    = bus.i_radicand[N-2:0];
   // Negative zero is treated as +0, so only a non-zero magnitude errors.
   assign w_neg    = bus.i_radicand[N-1] && (w_mag != '0);
   assign w_x_init = {{(c_XW-N+1){1'b0}}, w_mag} << Q;

   // Bring down the next two operand bits and form the trial divisor.
   assign w_rem_sh = {r_rem[c_RW-3:0], r_x[c_XW-1 -: 2]};
   assign w_trial  = {r_root, 2'b01};
   // The two remainder MSBs are zero between steps; folding them in keeps the
   // comparison exact over the whole register.
   assign w_fits   = (|r_rem[c_RW-1 -: 2]) || (w_rem_sh >= w_trial);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= c_IDLE;
         r_x        <= '0;
         r_rem      <= '0;
         r_root     <= '0;
         r_cnt      <= '0;
         r_neg      <= 1'b0;
         r_root_out <= '0;
         r_busy     <= 1'b0;
         r_complete <= 1'b0;
         r_error    <= 1'b0;
      end else begin
         case (r_state)
            c_IDLE: begin
               r_complete <= 1'b0;
               if (bus.i_start) begin
                  r_x     <= w_x_init;
                  r_rem   <= '0;
                  r_root  <= '0;
                  r_neg   <= w_neg;
                  r_busy  <= 1'b1;
                  r_error <= 1'b0;
                  // The error path makes a single dummy pass through BUSY so
                  // its result lands two edges after acceptance.
                  r_cnt   <= w_neg ? '0 : c_CNT_INIT;
                  r_state <= c_BUSY;
               end
            end
            c_BUSY: begin
               r_x    <= r_x << 2;
               r_rem  <= w_fits ? (w_rem_sh - w_trial) : w_rem_sh;
               r_root <= {r_root[c_ITER-2:0], w_fits};
               r_cnt  <= r_cnt - 1'b1;
               if (r_cnt == '0) begin
                  r_state <= c_DONE;
               end
            end
            c_DONE: begin
               r_complete <= 1'b1;
               r_busy     <= 1'b0;
               r_error    <= r_neg;
               r_root_out <= r_neg ? '0 : {{(N-c_ITER){1'b0}}, r_root};
               r_state    <= c_IDLE;
            end
            default: begin
               r_state <= c_IDLE;
            end
         endcase
      end
   end

   assign bus.o_root     = r_root_out;
   assign bus.o_busy     = r_busy;
   assign bus.o_complete = r_complete;
   assign bus.o_error    = r_error;

endmodule
`default_nettype wire
